rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: the ALU pipe (src0) and the load/store unit (src1).
- Keeps a busy scoreboard of destination registers with in-flight writes, so the issue stage can stall on RAW hazards.
- Sits between the execute/memory stages and the register file write port.
- Grants at most one write per cycle, round-robin when both sources contend.

---
 rtl/rv_pkg.sv | 12 +
 rtl/rf_wb_arbiter_rr_arb2.sv | 24 ++
 rtl/rf_wb_arbiter.sv | 82 ++++++++
 tb/tb_rf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared widths and the writeback request bundle used by the ALU and LSU writeback buses.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered priority bit.
// The priority bit moves only on contention, pointing away from the source just served.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  logic rr_q, rr_d;

  always_comb begin
    gnt0 = req0 & (~req1 | ~rr_q);
    gnt1 = req1 & (~req0 | rr_q);
    rr_d = rr_q;
    if (req0 & req1) rr_d = gnt0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback (1-cycle registered write)
// and tracks in-flight destination registers in a busy scoreboard for RAW stalls.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            iss_set,
  input  logic [AW-1:0]   iss_rd,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  wb_req_t alu_req, lsu_req, win_req;
  logic    gnt_alu, gnt_lsu;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (alu_req.valid),
    .req1 (lsu_req.valid),
    .gnt0 (gnt_alu),
    .gnt1 (gnt_lsu)
  );

  assign alu_ready = gnt_alu;
  assign lsu_ready = gnt_lsu;

  always_comb begin
    win_req    = gnt_lsu ? lsu_req : alu_req;
    // x0 handshakes are consumed but never reach the register file
    rf_we_d    = (gnt_alu | gnt_lsu) && (win_req.rd != '0);
    rf_waddr_d = rf_we_d ? win_req.rd   : rf_waddr_q;
    rf_wdata_d = rf_we_d ? win_req.data : rf_wdata_q;

    // Set is applied after clear so a newly dispatched writer keeps its bit
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (iss_set && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter with directed cases for reset, fairness, scoreboard and x0.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_set = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_set(iss_set), .iss_rd(iss_rd), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  typedef struct { int cyc; logic a; logic l; } rdy_e_t;
  typedef struct { int cyc; logic we; logic [4:0] addr; logic [31:0] data; logic [31:0] busy; } wr_e_t;
  rdy_e_t rdy_q[$];
  wr_e_t  wr_q[$];

  // Reference model: favoured source on contention, what the write port shows, pending set
  logic        lsu_favoured;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic        last_ga, last_gl;

  task automatic model_reset();
    lsu_favoured = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    last_ga = 1'b0; last_gl = 1'b0;
    rdy_q.delete();
    wr_q.delete();
  endtask

  // Called #1 after a rising edge; applies one cycle of stimulus and returns #1 after the next edge
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic is, input logic [4:0] ir);
    logic ga, gl, hs;
    logic [4:0] wrd;
    logic [31:0] wd, nb;
    rdy_e_t r;
    wr_e_t  w;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_set = is; iss_rd = ir;

    if (av && lv) begin
      ga = !lsu_favoured;
      gl = lsu_favoured;
      lsu_favoured = ga;
    end else begin
      ga = av;
      gl = lv;
    end
    r.cyc = cyc; r.a = ga; r.l = gl;
    rdy_q.push_back(r);

    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (is && ir != 0) nb[ir] = 1'b1;

    hs  = ga || gl;
    wrd = ga ? ard : lrd;
    wd  = ga ? ad : ld;
    m_we = hs && (wrd != 0);
    if (m_we) begin m_addr = wrd; m_data = wd; end
    m_busy = nb;
    last_ga = ga; last_gl = gl;

    w.cyc = cyc; w.we = m_we; w.addr = m_addr; w.data = m_data; w.busy = m_busy;
    wr_q.push_back(w);

    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
        rdy_e_t r;
        r = rdy_q.pop_front();
        if (r.cyc == cyc) begin
          chk("alu_ready", {63'd0, alu_ready}, {63'd0, r.a});
          chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, r.l});
        end
      end
      while (wr_q.size() > 0 && wr_q[0].cyc <= cyc - 1) begin
        wr_e_t w;
        w = wr_q.pop_front();
        if (w.cyc == cyc - 1) begin
          chk("rf_we", {63'd0, rf_we}, {63'd0, w.we});
          if (w.we) begin
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, w.addr});
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, w.data});
          end
          chk("busy", {32'd0, busy}, {32'd0, w.busy});
        end
      end
    end
  end

  // A second writer may only be dispatched to a register whose write commits this cycle
  always @(negedge clk) begin
    if (!rst && iss_set && iss_rd != 0)
      assert (!busy[iss_rd] || (rf_we && rf_waddr == iss_rd))
        else $error("issue to busy register %0d", iss_rd);
  end

  initial begin
    logic [4:0] pick;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("reset_busy", {32'd0, busy}, 64'd0);
    rst = 1'b0;

    // Reset mid-write
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("pre_reset_we", {63'd0, rf_we}, 64'd1);
    alu_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midreset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("midreset_busy", {32'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention fairness straight out of reset: ALU, LSU, ALU, LSU
    drive(1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hB0, 1'b0, 5'd0);
    chk("fair_waddr0", {59'd0, rf_waddr}, 64'd3);
    drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd4, 32'hB0, 1'b0, 5'd0);
    chk("fair_waddr1", {59'd0, rf_waddr}, 64'd4);
    drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd4, 32'hB1, 1'b0, 5'd0);
    chk("fair_waddr2", {59'd0, rf_waddr}, 64'd3);
    drive(1'b1, 5'd3, 32'hA2, 1'b1, 5'd4, 32'hB1, 1'b0, 5'd0);
    chk("fair_waddr3", {59'd0, rf_waddr}, 64'd4);

    // Single source
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    chk("lsu_we", {63'd0, rf_we}, 64'd1);
    chk("lsu_waddr", {59'd0, rf_waddr}, 64'd7);
    chk("lsu_wdata", {32'd0, rf_wdata}, 64'h12345678);

    // Scoreboard lifecycle
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("busy9_set", {63'd0, busy[9]}, 64'd1);
    idle();
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    chk("busy9_clear", {63'd0, busy[9]}, 64'd0);

    // Set and clear of the same register in one cycle
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    idle();
    drive(1'b1, 5'd9, 32'h98, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("busy9_collide", {63'd0, busy[9]}, 64'd1);
    drive(1'b1, 5'd9, 32'h97, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();

    // x0 handling
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    chk("x0_busy", {32'd0, busy}, 64'd0);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("x0_we", {63'd0, rf_we}, 64'd0);

    // Randomized traffic; sources hold requests until served, issue avoids busy registers
    for (int i = 0; i < 400; i++) begin
      logic av, lv, is;
      logic [4:0] ard, lrd;
      logic [31:0] ad, ld;
      if (alu_valid && !last_ga) begin
        av = 1'b1; ard = alu_rd; ad = alu_data;
      end else begin
        av = ($urandom_range(0, 99) < 60);
        ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = $urandom;
      end
      if (lsu_valid && !last_gl) begin
        lv = 1'b1; lrd = lsu_rd; ld = lsu_data;
      end else begin
        lv = ($urandom_range(0, 99) < 50);
        lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld = $urandom;
      end
      pick = 5'($urandom_range(0, 31));
      is = ($urandom_range(0, 99) < 50) &&
           (!m_busy[pick] || (m_we && m_addr == pick));
      drive(av, ard, ad, lv, lrd, ld, is, pick);
    end
    idle();
    idle();
    @(negedge clk); #1;
    chk("queues_drained", 64'(rdy_q.size() + wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
